// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory fetch controller.
`default_nettype none

package imem_pkg;

    localparam int PC_INCR = 4;
    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        LOAD  = 1'b1
    } state_e;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// Small instruction buffer with registered head, synchronous flush and
// push-while-full allowed when the head is being popped in the same cycle.
`default_nettype none

module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [PW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == (PW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage is cleared on reset so the head reads zero while empty after reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/imem_fetch_ctrl.sv
// Instruction-memory port owner: PC sequencing and buffered fetch toward
// decode in FETCH mode, sequential loader writes from address 0 in LOAD mode.
`default_nettype none

module imem_fetch_ctrl
    import imem_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2,
    parameter int          MEM_WORDS  = 256
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        imem_we,
    output logic [31:0] imem_wdata,
    input  logic        load_mode,
    input  logic        load_valid,
    input  logic [31:0] load_data,
    output logic        load_ready,
    output logic        load_full,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc
);

    localparam logic [31:0] LAST_ADDR = 32'((MEM_WORDS - 1) * PC_INCR);
    localparam logic [31:0] INCR      = 32'(PC_INCR);

    state_e       state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic [31:0]  load_addr_q, load_addr_d;
    logic         load_full_q, load_full_d;

    fetch_entry_t push_entry, head_entry;
    logic         fifo_flush, fifo_push, fifo_pop, fifo_full, fifo_empty;

    assign push_entry = '{pc: fetch_pc_q, instr: imem_rdata};

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (reset_n),
        .flush_i (fifo_flush),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .wdata_i (push_entry),
        .rdata_o (head_entry),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign if_valid  = (state_q == FETCH) && !fifo_empty;
    assign if_instr  = head_entry.instr;
    assign if_pc     = head_entry.pc;
    assign load_full = load_full_q;

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        load_addr_d = load_addr_q;
        load_full_d = load_full_q;
        fifo_flush  = 1'b0;
        fifo_push   = 1'b0;
        fifo_pop    = 1'b0;
        imem_addr   = fetch_pc_q;
        imem_we     = 1'b0;
        imem_wdata  = '0;
        load_ready  = 1'b0;

        case (state_q)
            FETCH: begin
                fifo_pop = !fifo_empty && if_ready;
                if (load_mode) begin
                    state_d     = LOAD;
                    fifo_flush  = 1'b1;
                    load_addr_d = '0;
                    load_full_d = 1'b0;
                end else if (redirect_valid) begin
                    fifo_flush = 1'b1;
                    fetch_pc_d = redirect_pc & ~32'h3;
                end else if (!fifo_full || fifo_pop) begin
                    fifo_push  = 1'b1;
                    fetch_pc_d = fetch_pc_q + INCR;
                end
            end
            LOAD: begin
                imem_addr  = load_addr_q;
                imem_wdata = load_data;
                // Gating with load_mode keeps a word offered during the exit cycle from being written.
                load_ready = load_mode && !load_full_q;
                imem_we    = load_valid && load_ready;
                if (!load_mode) begin
                    state_d    = FETCH;
                    fetch_pc_d = RESET_PC;
                    fifo_flush = 1'b1;
                end else if (imem_we) begin
                    load_addr_d = load_addr_q + INCR;
                    if (load_addr_q == LAST_ADDR) begin
                        load_full_d = 1'b1;
                    end
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= FETCH;
            fetch_pc_q  <= RESET_PC;
            load_addr_q <= '0;
            load_full_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            load_addr_q <= load_addr_d;
            load_full_q <= load_full_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_imem_fetch_ctrl.sv
// Directed self-checking bench for imem_fetch_ctrl with a behavioural memory.
`default_nettype none

module tb_imem_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_we;
    logic [31:0] imem_wdata;
    logic        load_mode;
    logic        load_valid;
    logic [31:0] load_data;
    logic        load_ready;
    logic        load_full;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;

    logic [31:0] mem [256];
    logic        pre_we;
    logic [7:0]  pre_idx;
    logic [31:0] pre_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    imem_fetch_ctrl #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (2),
        .MEM_WORDS  (256)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .imem_we        (imem_we),
        .imem_wdata     (imem_wdata),
        .load_mode      (load_mode),
        .load_valid     (load_valid),
        .load_data      (load_data),
        .load_ready     (load_ready),
        .load_full      (load_full),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc)
    );

    assign imem_rdata = mem[imem_addr[9:2]];

    always @(posedge clk) begin
        if (imem_we) mem[imem_addr[9:2]] <= imem_wdata;
        else if (pre_we) mem[pre_idx] <= pre_data;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n        = 1'b0;
        load_mode      = 1'b0;
        load_valid     = 1'b0;
        load_data      = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        if_ready       = 1'b0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        // Image: words 0..2 = 0x11,0x22,0x33, word i>=3 = 0x100+i
        reset_n = 1'b0; load_mode = 1'b0; load_valid = 1'b0; load_data = '0;
        redirect_valid = 1'b0; redirect_pc = '0; if_ready = 1'b0; pre_we = 1'b0;
        for (int i = 0; i < 256; i++) begin
            pre_idx  = 8'(i);
            pre_data = (i == 0) ? 32'h11 : (i == 1) ? 32'h22 : (i == 2) ? 32'h33 : 32'h100 + 32'(i);
            pre_we   = 1'b1;
            step();
        end
        pre_we = 1'b0;
        #1;
        checks++;
        if ({imem_addr, imem_we, imem_wdata, load_ready, load_full} !== 67'd0) begin
            errors++;
            $display("FAIL reset_port addr=%h we=%b wdata=%h lrdy=%b lfull=%b required all 0",
                     imem_addr, imem_we, imem_wdata, load_ready, load_full);
        end
        checks++;
        if ({if_valid, if_pc, if_instr} !== 65'd0) begin
            errors++;
            $display("FAIL reset_head valid=%b pc=%h instr=%h required 0/0/0", if_valid, if_pc, if_instr);
        end
    endtask

    task automatic test_fetch();
        logic [31:0] exp_i [3];
        exp_i[0] = 32'h11; exp_i[1] = 32'h22; exp_i[2] = 32'h33;
        do_reset();
        if_ready = 1'b1;
        #1;
        checks++;
        if ({if_valid, imem_addr} !== {1'b0, 32'h0}) begin
            errors++;
            $display("FAIL fetch_first valid=%b addr=%h required 0/00000000", if_valid, imem_addr);
        end
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if ({if_valid, if_pc, if_instr, imem_addr} !== {1'b1, 32'(4*k), exp_i[k], 32'(4*k+4)}) begin
                errors++;
                $display("FAIL fetch_seq%0d valid=%b pc=%h instr=%h addr=%h required 1/%h/%h/%h",
                         k, if_valid, if_pc, if_instr, imem_addr, 32'(4*k), exp_i[k], 32'(4*k+4));
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] exp_i [3];
        exp_i[0] = 32'h22; exp_i[1] = 32'h33; exp_i[2] = 32'h103;
        do_reset();
        for (int c = 1; c <= 5; c++) begin
            step();
            checks++;
            if ({if_valid, if_pc, if_instr, imem_addr} !== {1'b1, 32'h0, 32'h11, (c == 1) ? 32'h4 : 32'h8}) begin
                errors++;
                $display("FAIL stall_hold%0d valid=%b pc=%h instr=%h addr=%h required 1/0/11/%h",
                         c, if_valid, if_pc, if_instr, imem_addr, (c == 1) ? 32'h4 : 32'h8);
            end
        end
        if_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if ({if_valid, if_pc, if_instr, imem_addr} !== {1'b1, 32'(4*k+4), exp_i[k], 32'(4*k+12)}) begin
                errors++;
                $display("FAIL stall_release%0d valid=%b pc=%h instr=%h addr=%h required 1/%h/%h/%h",
                         k, if_valid, if_pc, if_instr, imem_addr, 32'(4*k+4), exp_i[k], 32'(4*k+12));
            end
        end
    endtask

    task automatic test_redirect();
        do_reset();
        step();
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h43;
        if_ready       = 1'b1;
        step();
        redirect_valid = 1'b0;
        if_ready       = 1'b0;
        #1;
        checks++;
        if ({if_valid, imem_addr} !== {1'b0, 32'h40}) begin
            errors++;
            $display("FAIL redir_n1 valid=%b addr=%h required 0/00000040", if_valid, imem_addr);
        end
        step();
        checks++;
        if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h40, 32'h110}) begin
            errors++;
            $display("FAIL redir_n2 valid=%b pc=%h instr=%h required 1/40/110", if_valid, if_pc, if_instr);
        end
        if_ready = 1'b1;
        step();
        checks++;
        if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h44, 32'h111}) begin
            errors++;
            $display("FAIL redir_next valid=%b pc=%h instr=%h required 1/44/111", if_valid, if_pc, if_instr);
        end
    endtask

    task automatic test_load();
        logic [31:0] words [3];
        words[0] = 32'hA; words[1] = 32'hB; words[2] = 32'hC;
        do_reset();
        load_mode = 1'b1;
        step();
        #1;
        checks++;
        if ({load_ready, imem_we, imem_addr, if_valid} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL load_enter rdy=%b we=%b addr=%h valid=%b required 1/0/0/0",
                     load_ready, imem_we, imem_addr, if_valid);
        end
        for (int w = 0; w < 3; w++) begin
            load_valid = 1'b1;
            load_data  = words[w];
            #1;
            checks++;
            if ({imem_we, imem_addr, imem_wdata} !== {1'b1, 32'(4*w), words[w]}) begin
                errors++;
                $display("FAIL load_wr%0d we=%b addr=%h wdata=%h required 1/%h/%h",
                         w, imem_we, imem_addr, imem_wdata, 32'(4*w), words[w]);
            end
            step();
            load_valid = 1'b0;
            #1;
            checks++;
            if ({imem_we, imem_addr} !== {1'b0, 32'(4*w+4)}) begin
                errors++;
                $display("FAIL load_gap%0d we=%b addr=%h required 0/%h", w, imem_we, imem_addr, 32'(4*w+4));
            end
            step();
        end
        load_mode  = 1'b0;
        load_valid = 1'b1;
        load_data  = 32'hBAD;
        #1;
        checks++;
        if ({load_ready, imem_we} !== 2'b00) begin
            errors++;
            $display("FAIL load_exit rdy=%b we=%b required 0/0", load_ready, imem_we);
        end
        step();
        load_valid = 1'b0;
        if_ready   = 1'b1;
        #1;
        checks++;
        if ({if_valid, imem_addr} !== {1'b0, 32'h0}) begin
            errors++;
            $display("FAIL load_refetch valid=%b addr=%h required 0/00000000", if_valid, imem_addr);
        end
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if ({if_valid, if_pc, if_instr} !== {1'b1, 32'(4*k), words[k]}) begin
                errors++;
                $display("FAIL load_readback%0d valid=%b pc=%h instr=%h required 1/%h/%h",
                         k, if_valid, if_pc, if_instr, 32'(4*k), words[k]);
            end
        end
    endtask

    task automatic test_load_full();
        int bad = 0;
        do_reset();
        load_mode = 1'b1;
        step();
        for (int i = 0; i < 256; i++) begin
            load_valid = 1'b1;
            load_data  = 32'h5000_0000 + 32'(i);
            #1;
            if ({imem_we, imem_addr, load_full} !== {1'b1, 32'(4*i), 1'b0}) bad++;
            step();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL full_stream bad_cycles=%0d required 0", bad);
        end
        load_data = 32'hDEAD_BEEF;
        #1;
        checks++;
        if ({load_full, load_ready, imem_we} !== 3'b100) begin
            errors++;
            $display("FAIL full_257 full=%b rdy=%b we=%b required 1/0/0", load_full, load_ready, imem_we);
        end
        step();
        checks++;
        if (mem[0] !== 32'h5000_0000 || load_full !== 1'b1) begin
            errors++;
            $display("FAIL full_nowrap mem0=%h full=%b required 50000000/1", mem[0], load_full);
        end
    endtask

    task automatic test_reset_mid();
        // Still in LOAD, full, load_valid high
        reset_n = 1'b0;
        #1;
        checks++;
        if ({imem_we, imem_wdata, load_ready, load_full, imem_addr, if_valid} !== 67'd0) begin
            errors++;
            $display("FAIL rst_load we=%b wdata=%h rdy=%b full=%b addr=%h valid=%b required all 0",
                     imem_we, imem_wdata, load_ready, load_full, imem_addr, if_valid);
        end
        load_mode = 1'b0; load_valid = 1'b0; if_ready = 1'b1;
        step();
        reset_n = 1'b1;
        step();
        checks++;
        if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h0, 32'h5000_0000}) begin
            errors++;
            $display("FAIL rst_load_fetch valid=%b pc=%h instr=%h required 1/0/50000000", if_valid, if_pc, if_instr);
        end
        if_ready = 1'b0;
        step();
        step();
        step();
        reset_n = 1'b0;
        #1;
        checks++;
        if ({if_valid, if_pc, if_instr, imem_addr} !== 97'd0) begin
            errors++;
            $display("FAIL rst_stall valid=%b pc=%h instr=%h addr=%h required all 0", if_valid, if_pc, if_instr, imem_addr);
        end
        step();
        reset_n  = 1'b1;
        if_ready = 1'b1;
        step();
        checks++;
        if ({if_valid, if_pc, if_instr, imem_addr} !== {1'b1, 32'h0, 32'h5000_0000, 32'h4}) begin
            errors++;
            $display("FAIL rst_stall_fetch valid=%b pc=%h instr=%h addr=%h required 1/0/50000000/4",
                     if_valid, if_pc, if_instr, imem_addr);
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_stall();
        test_redirect();
        test_load();
        test_load_full();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
